// File: rtl/pg_seq_pkg.sv
// Shared types and default timing for the power-gating domain sequencer.
package pg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISO,
    WAKE,
    DEISO
  } pg_state_e;

  localparam int ISO_DLY_DEF  = 4;
  localparam int WAKE_DLY_DEF = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pg_domain_sequencer_arb.sv
// Round-robin arbiter: lowest requesting index at or above ptr+1, wrapping.
module pg_rr_arbiter #(
  parameter int N_DOM = 10,
  parameter int IW    = $clog2(N_DOM)
) (
  input  logic [N_DOM-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_DOM-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_vld
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int off = 1; off <= N_DOM; off++) begin
      idx = IW'((int'(ptr) + off) % N_DOM);
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pg_domain_sequencer.sv
// Shared power-gating sequencer: one domain at a time, isolation before
// sleep on the way down, sleep release then de-isolation on the way up.
module pg_domain_sequencer
  import pg_seq_pkg::*;
#(
  parameter int N_DOM    = 10,
  parameter int ISO_DLY  = ISO_DLY_DEF,
  parameter int WAKE_DLY = WAKE_DLY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_DOM-1:0] sensor,
  input  logic             en,
  output logic [N_DOM-1:0] isg,
  output logic [N_DOM-1:0] slp,
  output logic [N_DOM-1:0] pwr_ok,
  output logic             busy
);

  localparam int CNT_W = $clog2(max2(ISO_DLY, WAKE_DLY) + 1);
  localparam int IW    = $clog2(N_DOM);

  pg_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [N_DOM-1:0] gsel, gsel_n;
  logic [N_DOM-1:0] isg_n, slp_n, pwr_ok_n;
  logic [N_DOM-1:0] pwr_state, pwr_state_n;
  logic [N_DOM-1:0] pending, gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_vld;

  assign pending = sensor ^ pwr_state;
  assign busy    = (state != IDLE);

  pg_rr_arbiter #(.N_DOM(N_DOM), .IW(IW)) u_arb (
    .req     (pending),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= IW'(N_DOM - 1);
      gsel      <= '0;
      isg       <= '0;
      slp       <= '0;
      pwr_ok    <= '1;
      pwr_state <= '1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
      gsel      <= gsel_n;
      isg       <= isg_n;
      slp       <= slp_n;
      pwr_ok    <= pwr_ok_n;
      pwr_state <= pwr_state_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    ptr_n       = ptr;
    gsel_n      = gsel;
    isg_n       = isg;
    slp_n       = slp;
    pwr_ok_n    = pwr_ok;
    pwr_state_n = pwr_state;
    unique case (state)
      IDLE: begin
        if (en && gnt_vld) begin
          ptr_n  = gnt_idx;
          gsel_n = gnt;
          // Direction is latched here; later sensor moves wait for IDLE.
          if (|(sensor & gnt)) begin
            slp_n   = slp & ~gnt;
            cnt_n   = CNT_W'(WAKE_DLY - 1);
            state_n = WAKE;
          end else begin
            isg_n    = isg | gnt;
            pwr_ok_n = pwr_ok & ~gnt;
            cnt_n    = CNT_W'(ISO_DLY - 1);
            state_n  = ISO;
          end
        end
      end
      ISO: begin
        if (cnt == '0) begin
          slp_n       = slp | gsel;
          pwr_state_n = pwr_state & ~gsel;
          state_n     = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WAKE: begin
        if (cnt == '0) state_n = DEISO;
        else           cnt_n   = cnt - 1'b1;
      end
      DEISO: begin
        isg_n       = isg & ~gsel;
        pwr_ok_n    = pwr_ok | gsel;
        pwr_state_n = pwr_state | gsel;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pg_domain_sequencer.sv
// Directed bench for pg_domain_sequencer with per-cycle invariant checks.
module tb_pg_domain_sequencer;

  logic       clk;
  logic       rst_n;
  logic [9:0] sensor;
  logic       en;
  logic [9:0] isg, slp, pwr_ok;
  logic       busy;

  int n_chk;
  int n_fail;

  pg_domain_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sensor (sensor),
    .en     (en),
    .isg    (isg),
    .slp    (slp),
    .pwr_ok (pwr_ok),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic inv();
    chk("inv_slp_iso", 32'(slp & ~isg), 32'h0);
    chk("inv_pwr_ok", 32'(pwr_ok & (isg | slp)), 32'h0);
    chk("inv_inflight", 32'($countones(isg ^ slp) <= 1), 32'h1);
  endtask

  task automatic tick();
    @(negedge clk);
    inv();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    sensor = 10'h3FF;
    #12;
    rst_n = 1'b1;

    // 1: all domains demanded, nothing moves
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t1_isg", 32'(isg), 32'h0);
      chk("t1_slp", 32'(slp), 32'h0);
      chk("t1_pwr_ok", 32'(pwr_ok), 32'h3FF);
      chk("t1_busy", 32'(busy), 32'h0);
    end

    // 2: power down domain 3
    sensor = 10'h3F7;
    tick();
    chk("t2_isg", 32'(isg), 32'h008);
    chk("t2_pwr_ok", 32'(pwr_ok), 32'h3F7);
    chk("t2_slp0", 32'(slp), 32'h000);
    chk("t2_busy0", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_slp_wait", 32'(slp), 32'h000);
      chk("t2_busy", 32'(busy), 32'h1);
    end
    tick();
    chk("t2_slp", 32'(slp), 32'h008);
    chk("t2_busy_end", 32'(busy), 32'h0);
    tick();
    chk("t2_idle", 32'(busy), 32'h0);

    // 3: power domain 3 back up
    sensor = 10'h3FF;
    tick();
    chk("t3_slp", 32'(slp), 32'h000);
    chk("t3_isg0", 32'(isg), 32'h008);
    chk("t3_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("t3_isg_hold", 32'(isg), 32'h008);
      chk("t3_pwr_ok_hold", 32'(pwr_ok), 32'h3F7);
    end
    tick();
    chk("t3_isg", 32'(isg), 32'h000);
    chk("t3_pwr_ok", 32'(pwr_ok), 32'h3FF);
    tick();
    chk("t3_busy_end", 32'(busy), 32'h0);

    // 4: reset puts ptr at 9; domains 0 and 3 drop together
    rst_n = 1'b0;
    #1;
    sensor = 10'h3F6;
    rst_n  = 1'b1;
    tick();
    chk("t4_isg_d0", 32'(isg), 32'h001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_d0_only", 32'(isg), 32'h001);
    end
    tick();
    chk("t4_slp_d0", 32'(slp), 32'h001);
    chk("t4_gap", 32'(busy), 32'h0);
    chk("t4_gap_isg", 32'(isg), 32'h001);
    tick();
    chk("t4_isg_d3", 32'(isg), 32'h009);
    chk("t4_slp_d3_wait", 32'(slp), 32'h001);
    chk("t4_busy_d3", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_slp_both", 32'(slp), 32'h009);
    chk("t4_pwr_ok", 32'(pwr_ok), 32'h3F6);

    // 5: en=0 mid power-down of domain 5, domain 7 waits
    sensor = 10'h3D6;
    tick();
    chk("t5_isg_d5", 32'(isg), 32'h029);
    en     = 1'b0;
    sensor = 10'h356;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_busy", 32'(busy), 32'h1);
    end
    tick();
    chk("t5_slp_d5", 32'(slp), 32'h029);
    chk("t5_done", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_busy", 32'(busy), 32'h0);
      chk("t5_hold_isg", 32'(isg), 32'h029);
    end
    en = 1'b1;
    tick();
    chk("t5_isg_d7", 32'(isg), 32'h0A9);
    chk("t5_busy_d7", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_slp_d7", 32'(slp), 32'h0A9);
    chk("t5_pwr_ok", 32'(pwr_ok), 32'h356);

    // 6: async reset while domain 2 is waking
    sensor = 10'h352;
    tick();
    chk("t6_isg_d2", 32'(isg), 32'h0AD);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_slp_d2", 32'(slp), 32'h0AD);
    sensor = 10'h356;
    tick();
    chk("t6_wake", 32'(slp), 32'h0A9);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_mid_wake", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_isg", 32'(isg), 32'h000);
    chk("t6_rst_slp", 32'(slp), 32'h000);
    chk("t6_rst_pwr_ok", 32'(pwr_ok), 32'h3FF);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    #10;
    rst_n  = 1'b1;
    sensor = 10'h3FF;
    tick();
    chk("t6_post_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
